// File: rtl/i2c_arb_pkg.sv
// Shared state encoding and requester port indices for the I2C bus arbiter.
// Types and constants only; no logic.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int SENSOR = 0;
  localparam int LCD    = 1;

endpackage

// File: rtl/arb_cmd_mux.sv
// Forwards the granted port's command bundle to the master and routes responses back to it only.
// Purely combinational; an ungranted port sees zeros, and its start pulses are dropped rather than queued.
module arb_cmd_mux
  import i2c_arb_pkg::*;
(
  input  logic [1:0] gnt_i,
  input  logic [1:0] start_i,
  input  logic [6:0] addr0_i,
  input  logic [6:0] addr1_i,
  input  logic [1:0] rw_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  input  logic       m_done_i,
  input  logic [7:0] m_rdata_i,
  input  logic       m_nack_i,
  output logic       m_start_o,
  output logic [6:0] m_addr_o,
  output logic       m_rw_o,
  output logic [7:0] m_wdata_o,
  output logic [1:0] done_o,
  output logic [7:0] rdata0_o,
  output logic [7:0] rdata1_o,
  output logic [1:0] err_o
);

  always_comb begin
    m_start_o = 1'b0;
    m_addr_o  = '0;
    m_rw_o    = 1'b0;
    m_wdata_o = '0;
    if (gnt_i[SENSOR]) begin
      m_start_o = start_i[SENSOR];
      m_addr_o  = addr0_i;
      m_rw_o    = rw_i[SENSOR];
      m_wdata_o = wdata0_i;
    end else if (gnt_i[LCD]) begin
      m_start_o = start_i[LCD];
      m_addr_o  = addr1_i;
      m_rw_o    = rw_i[LCD];
      m_wdata_o = wdata1_i;
    end
  end

  assign done_o   = gnt_i & {2{m_done_i}};
  assign err_o    = gnt_i & {2{m_nack_i}};
  assign rdata0_o = gnt_i[SENSOR] ? m_rdata_i : 8'd0;
  assign rdata1_o = gnt_i[LCD]    ? m_rdata_i : 8'd0;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Per-transaction arbiter sharing one I2C byte master between the sensor (port 0) and LCD (port 1).
// Grant follows request by 1 cycle; a released bus must stay non-busy BUS_FREE_CYCLES before the next grant.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int BUS_FREE_CYCLES = 5,
  parameter int TIMEOUT_CYCLES  = 20000,
  parameter int MAX_CONSEC      = 4,
  parameter int CNT_W           = 15
) (
  input  logic       clk_1MHz,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       start0,
  input  logic       start1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       err0,
  output logic       err1,
  output logic       m_start,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_wdata,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic [7:0] m_rdata,
  input  logic       m_nack,
  output logic       timeout_pulse,
  output logic       timeout_src
);

  localparam int CONS_W = $clog2(MAX_CONSEC + 1);

  arb_state_e        state_q;
  logic [1:0]        gnt_q;
  logic [1:0]        lockout_q;
  logic [CNT_W-1:0]  free_q;
  logic [CNT_W-1:0]  tmo_q;
  logic [CONS_W-1:0] consec_q;
  logic              timeout_pulse_q;
  logic              timeout_src_q;

  logic [1:0] req;
  logic [1:0] elig;
  logic       held_req;
  logic       sensor_wins;

  assign req         = {req1, req0};
  assign elig        = req & ~lockout_q;
  assign held_req    = (state_q == GRANT1) ? req1 : req0;
  assign sensor_wins = elig[SENSOR] && (!elig[LCD] || consec_q < CONS_W'(MAX_CONSEC));

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      gnt_q           <= '0;
      lockout_q       <= '0;
      free_q          <= '0;
      tmo_q           <= '0;
      consec_q        <= '0;
      timeout_pulse_q <= 1'b0;
      timeout_src_q   <= 1'b0;
    end else begin
      timeout_pulse_q <= 1'b0;
      lockout_q       <= lockout_q & req;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (sensor_wins) begin
            state_q <= GRANT0;
            gnt_q   <= 2'b01;
            if (!req[LCD])
              consec_q <= '0;
            else if (consec_q < CONS_W'(MAX_CONSEC))
              consec_q <= consec_q + CONS_W'(1);
          end else if (elig[LCD]) begin
            state_q  <= GRANT1;
            gnt_q    <= 2'b10;
            consec_q <= '0;
          end
        end
        GRANT0, GRANT1: begin
          // A requester that drops req on the timeout cycle gets a clean release, not a lockout.
          if (!held_req) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
            free_q  <= '0;
          end else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q         <= RELEASE;
            gnt_q           <= '0;
            free_q          <= '0;
            timeout_pulse_q <= 1'b1;
            timeout_src_q   <= (state_q == GRANT1);
            lockout_q       <= (lockout_q & req) | gnt_q;
          end else begin
            tmo_q <= tmo_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (m_busy)
            free_q <= '0;
          else if (free_q == CNT_W'(BUS_FREE_CYCLES - 1)) begin
            state_q <= IDLE;
            free_q  <= '0;
          end else
            free_q <= free_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0          = gnt_q[SENSOR];
  assign gnt1          = gnt_q[LCD];
  assign timeout_pulse = timeout_pulse_q;
  assign timeout_src   = timeout_src_q;

  arb_cmd_mux u_mux (
    .gnt_i     (gnt_q),
    .start_i   ({start1, start0}),
    .addr0_i   (addr0),
    .addr1_i   (addr1),
    .rw_i      ({rw1, rw0}),
    .wdata0_i  (wdata0),
    .wdata1_i  (wdata1),
    .m_done_i  (m_done),
    .m_rdata_i (m_rdata),
    .m_nack_i  (m_nack),
    .m_start_o (m_start),
    .m_addr_o  (m_addr),
    .m_rw_o    (m_rw),
    .m_wdata_o (m_wdata),
    .done_o    ({done1, done0}),
    .rdata0_o  (rdata0),
    .rdata1_o  (rdata1),
    .err_o     ({err1, err0})
  );

  gnt_onehot_a: assert property (@(posedge clk_1MHz) disable iff (reset) !(gnt_q[0] && gnt_q[1]));

endmodule
